alu_issue_ctrl: RTL

Sequential issue/capture controller that drives the datapath ALU: it accepts one operation through a start handshake, presents the opcode and operands to the ALU, waits an opcode-dependent settle time, and captures the 64-bit `z` result into held HI/LO result registers. It sits between the control sequencer and the ALU, acting as the initiator side of the ALU's opcode/operand/result interface. The block serialises operations, so exactly one is in flight at a time.

---
 rtl/alu_issue_ctrl_pkg.sv | 28 ++
 rtl/alu_issue_ctrl_settle_counter.sv | 28 ++
 rtl/alu_issue_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/alu_issue_ctrl_pkg.sv
// Shared ALU definitions: opcode constants, issue FSM state encoding and
// opcode classification helpers used by the issue controller and the ALU.
package alu_defs;

    // Opcode constants referenced by the issue controller
    localparam logic [4:0] OP_LOAD = 5'b00000;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_LAST = 5'b10010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // mul/div take the long settle time and produce a full 64-bit result
    function automatic logic is_muldiv(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

    function automatic logic is_legal(input logic [4:0] op);
        return op <= OP_LAST;
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_settle_counter.sv
// Settle-time down counter: loaded on accept, decremented while the ALU
// settles, flags the final settle cycle (count == 1).
module alu_settle_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_last
);

    logic [CNT_W-1:0] r_cnt;

    // Load has priority over decrement; never wraps below zero
    always_ff @(posedge clk or posedge clr) begin
        if (clr)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_load_val;
        else if (i_dec && (r_cnt != '0))
            r_cnt <= r_cnt - 1'b1;
    end

    assign o_last = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU issue/capture controller: accepts one op, drives the ALU with held
// opcode/operands, waits the opcode-dependent settle time and captures the
// 64-bit result into HI/LO registers. One op in flight at a time.
module alu_issue_ctrl
    import alu_defs::*;
#(
    parameter int BASIC_SETTLE  = 1,
    parameter int MULDIV_SETTLE = 4
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic [4:0]  op_in,
    input  logic [31:0] a_in,
    input  logic [31:0] b_in,
    output logic [4:0]  alu_opcode,
    output logic [31:0] alu_y,
    output logic [31:0] alu_b,
    input  logic [63:0] alu_z,
    output logic        busy,
    output logic        result_valid,
    input  logic        result_ack,
    output logic [31:0] z_hi,
    output logic [31:0] z_lo,
    output logic        wide,
    output logic        err
);

    localparam int CNT_W = 8;

    state_t           r_state;
    state_t           w_next;
    logic             w_accept;
    logic             w_legal;
    logic             w_last;
    logic             w_capture;
    logic [CNT_W-1:0] w_settle;

    logic [4:0]  r_opcode;
    logic [31:0] r_y;
    logic [31:0] r_b;
    logic [31:0] r_z_hi;
    logic [31:0] r_z_lo;
    logic        r_wide;
    logic        r_err;

    assign w_accept  = (r_state == ST_IDLE) && start;
    assign w_legal   = is_legal(op_in);
    assign w_capture = (r_state == ST_EXEC) && w_last;
    assign w_settle  = is_muldiv(op_in) ? CNT_W'(MULDIV_SETTLE) : CNT_W'(BASIC_SETTLE);

    alu_settle_counter #(.CNT_W(CNT_W)) u_settle (
        .clk        (clk),
        .clr        (clr),
        .i_load     (w_accept && w_legal),
        .i_load_val (w_settle),
        .i_dec      (r_state == ST_EXEC),
        .o_last     (w_last)
    );

    // State register
    always_ff @(posedge clk or posedge clr) begin
        if (clr)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    // Next-state: illegal ops skip EXEC; ack in DONE wins over any start
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (start)      w_next = w_legal ? ST_EXEC : ST_DONE;
            ST_EXEC: if (w_last)     w_next = ST_DONE;
            ST_DONE: if (result_ack) w_next = ST_IDLE;
            default:                 w_next = ST_IDLE;
        endcase
    end

    // Status outputs decoded from the registered state only
    always_comb begin
        busy         = 1'b0;
        result_valid = 1'b0;
        case (r_state)
            ST_EXEC: busy = 1'b1;
            ST_DONE: begin
                busy         = 1'b1;
                result_valid = 1'b1;
            end
            default: ;
        endcase
    end

    // ALU request registers: written only on the accept edge
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_opcode <= '0;
            r_y      <= '0;
            r_b      <= '0;
        end else if (w_accept) begin
            r_opcode <= op_in;
            r_y      <= a_in;
            r_b      <= b_in;
        end
    end

    // Result registers: illegal accept reports err with a zeroed result,
    // otherwise the ALU output is captured on the last settle cycle
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_z_hi <= '0;
            r_z_lo <= '0;
            r_wide <= 1'b0;
            r_err  <= 1'b0;
        end else if (w_accept && !w_legal) begin
            r_z_hi <= '0;
            r_z_lo <= '0;
            r_wide <= 1'b0;
            r_err  <= 1'b1;
        end else if (w_capture) begin
            r_z_hi <= alu_z[63:32];
            r_z_lo <= alu_z[31:0];
            r_wide <= is_muldiv(r_opcode);
            r_err  <= 1'b0;
        end
    end

    assign alu_opcode = r_opcode;
    assign alu_y      = r_y;
    assign alu_b      = r_b;
    assign z_hi       = r_z_hi;
    assign z_lo       = r_z_lo;
    assign wide       = r_wide;
    assign err        = r_err;

endmodule
